// File: rtl/irq_scheduler_if.sv
// rtl/irq_scheduler_if.sv - request, mask and handshake bundle between core and irq_scheduler
interface irq_scheduler_if #(
    parameter int NREQ = 8,
    parameter int IDW  = 3
);
    logic            en_inter;
    logic [NREQ-1:0] int_req;
    logic            mask_we;
    logic [NREQ-1:0] mask_wdata;
    logic            int_ack;
    logic            int_done;
    // "int" is a SystemVerilog keyword, so the request to the core is named intr
    logic            intr;
    logic [IDW-1:0]  int_num;
    logic [IDW-1:0]  svc_num;
    logic            in_service;
    logic [NREQ-1:0] pending;

    modport master (
        output en_inter, int_req, mask_we, mask_wdata, int_ack, int_done,
        input  intr, int_num, svc_num, in_service, pending
    );

    modport slave (
        input  en_inter, int_req, mask_we, mask_wdata, int_ack, int_done,
        output intr, int_num, svc_num, in_service, pending
    );
endinterface

// File: rtl/irq_scheduler.sv
// rtl/irq_scheduler.sv - edge-capturing, maskable, non-nesting interrupt scheduler
module irq_scheduler #(
    parameter int NREQ = 8,
    parameter int IDW  = 3
) (
    input  logic             clk,
    input  logic             rst,
    irq_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t          state;
    logic [NREQ-1:0] prev;
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] pending;
    logic            intr;
    logic [IDW-1:0]  int_num;
    logic [IDW-1:0]  svc_num;
    logic            in_service;

    logic [NREQ-1:0] mask_next;
    logic [NREQ-1:0] edges;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] ack_clr;
    logic [IDW-1:0]  winner;
    logic            found;
    logic            take_ack;
    logic            withdraw;

    // A mask write takes effect for the selection made on the same edge
    assign mask_next = bus.mask_we ? bus.mask_wdata : mask;
    assign edges     = bus.int_req & ~prev;
    assign eligible  = pending & ~mask_next;
    assign take_ack  = (state == REQ) && bus.int_ack;
    assign withdraw  = (state == REQ) && !bus.int_ack && (!bus.en_inter || mask_next[int_num]);

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (eligible[i] && !found) begin
                winner = IDW'(i);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        ack_clr = '0;
        ack_clr[int_num] = take_ack;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            prev       <= '0;
            mask       <= '0;
            pending    <= '0;
            intr       <= 1'b0;
            int_num    <= '0;
            svc_num    <= '0;
            in_service <= 1'b0;
        end else begin
            prev <= bus.int_req;
            mask <= mask_next;
            // A new edge beats the acknowledge clear so the event is not lost
            pending <= (pending & ~ack_clr) | edges;

            case (state)
                IDLE: begin
                    if (bus.en_inter && found) begin
                        int_num <= winner;
                        intr    <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (take_ack) begin
                        svc_num    <= int_num;
                        intr       <= 1'b0;
                        in_service <= 1'b1;
                        state      <= SERVICE;
                    end else if (withdraw) begin
                        intr  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SERVICE: begin
                    if (bus.int_done) begin
                        in_service <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    intr       <= 1'b0;
                    in_service <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.intr       = intr;
    assign bus.int_num    = int_num;
    assign bus.svc_num    = svc_num;
    assign bus.in_service = in_service;
    assign bus.pending    = pending;

endmodule

// File: tb/tb_irq_scheduler.sv
// tb/tb_irq_scheduler.sv - directed bench for irq_scheduler with a cycle-level reference model
module tb_irq_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    irq_scheduler_if bus ();

    irq_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: mode 0 = nothing presented, 1 = line m_num presented, 2 = line m_svc in service
    logic [7:0] m_pend, m_mask, m_prev;
    logic [2:0] m_num, m_svc;
    int         m_mode;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'h00;
            m_num  = 3'd0;  m_svc  = 3'd0;  m_mode = 0;
        end else begin
            logic [7:0] new_mask;
            logic [7:0] next_pend;
            new_mask  = bus.mask_we ? bus.mask_wdata : m_mask;
            next_pend = m_pend;
            if (m_mode == 0) begin
                if (bus.en_inter) begin
                    for (int i = 7; i >= 0; i--)
                        if (m_pend[i] && !new_mask[i]) begin
                            m_num  = 3'(i);
                            m_mode = 1;
                        end
                end
            end else if (m_mode == 1) begin
                if (bus.int_ack) begin
                    next_pend[m_num] = 1'b0;
                    m_svc  = m_num;
                    m_mode = 2;
                end else if (!bus.en_inter || new_mask[m_num]) begin
                    m_mode = 0;
                end
            end else if (bus.int_done) begin
                m_mode = 0;
            end
            m_pend = next_pend | (bus.int_req & ~m_prev);
            m_prev = bus.int_req;
            m_mask = new_mask;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_intr",    32'(bus.intr),       32'(m_mode == 1));
        chk("model_in_svc",  32'(bus.in_service), 32'(m_mode == 2));
        chk("model_pending", 32'(bus.pending),    32'(m_pend));
        if (m_mode == 1) chk("model_int_num", 32'(bus.int_num), 32'(m_num));
        if (m_mode == 2) chk("model_svc_num", 32'(bus.svc_num), 32'(m_svc));
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic serve(input logic [2:0] line);
        bus.int_ack = 1'b1;
        tick();
        chk("ack_intr_low", 32'(bus.intr), 32'd0);
        chk("ack_in_svc",   32'(bus.in_service), 32'd1);
        chk("ack_svc_num",  32'(bus.svc_num), 32'(line));
        bus.int_ack  = 1'b0;
        bus.int_done = 1'b1;
        tick();
        chk("done_in_svc", 32'(bus.in_service), 32'd0);
        bus.int_done = 1'b0;
    endtask

    initial begin
        bus.en_inter = 1'b0; bus.int_req = 8'h00; bus.mask_we = 1'b0;
        bus.mask_wdata = 8'h00; bus.int_ack = 1'b0; bus.int_done = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_intr",    32'(bus.intr), 32'd0);
        chk("rst_in_svc",  32'(bus.in_service), 32'd0);
        chk("rst_pending", 32'(bus.pending), 32'h00);
        chk("rst_int_num", 32'(bus.int_num), 32'd0);
        chk("rst_svc_num", 32'(bus.svc_num), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.en_inter = 1'b1;
        tick();

        // single pulse on line 5
        bus.int_req = 8'h20; tick();
        chk("t1_pending", 32'(bus.pending), 32'h20);
        chk("t1_intr_e0", 32'(bus.intr), 32'd0);
        bus.int_req = 8'h00; tick();
        chk("t1_intr", 32'(bus.intr), 32'd1);
        chk("t1_num",  32'(bus.int_num), 32'd5);
        serve(3'd5);
        chk("t1_pend_clr", 32'(bus.pending), 32'h00);
        tick();

        // simultaneous edges 4 and 7
        bus.int_req = 8'h90; tick();
        bus.int_req = 8'h00; tick();
        chk("t2_num4", 32'(bus.int_num), 32'd4);
        serve(3'd4);
        tick();
        chk("t2_num7", 32'(bus.int_num), 32'd7);
        serve(3'd7);
        tick();

        // line 0 arrives while line 4 is presented: no preemption
        bus.int_req = 8'h10; tick();
        bus.int_req = 8'h00; tick();
        bus.int_req = 8'h01; tick();
        bus.int_req = 8'h00; tick();
        chk("t2_hold4",    32'(bus.int_num), 32'd4);
        chk("t2_pend_0_4", 32'(bus.pending), 32'h11);
        serve(3'd4);
        tick();
        chk("t2_num0", 32'(bus.int_num), 32'd0);
        serve(3'd0);
        tick();

        // masked line captures but is not presented until unmasked
        bus.mask_we = 1'b1; bus.mask_wdata = 8'h08; bus.int_req = 8'h08; tick();
        bus.mask_we = 1'b0; bus.int_req = 8'h00; tick();
        chk("t3_pending", 32'(bus.pending), 32'h08);
        tick();
        chk("t3_masked", 32'(bus.intr), 32'd0);
        bus.mask_we = 1'b1; bus.mask_wdata = 8'h00; tick();
        bus.mask_we = 1'b0;
        chk("t3_intr", 32'(bus.intr), 32'd1);
        chk("t3_num",  32'(bus.int_num), 32'd3);
        serve(3'd3);
        tick();

        // withdraw by en_inter and by mask write
        bus.int_req = 8'h04; tick();
        bus.int_req = 8'h00; tick();
        chk("t4_num", 32'(bus.int_num), 32'd2);
        bus.en_inter = 1'b0; tick();
        chk("t4_wd_intr", 32'(bus.intr), 32'd0);
        chk("t4_wd_pend", 32'(bus.pending), 32'h04);
        tick();
        bus.en_inter = 1'b1; tick();
        chk("t4_re_intr", 32'(bus.intr), 32'd1);
        chk("t4_re_num",  32'(bus.int_num), 32'd2);
        bus.mask_we = 1'b1; bus.mask_wdata = 8'h04; tick();
        chk("t4_mwd_intr", 32'(bus.intr), 32'd0);
        bus.mask_wdata = 8'h00; tick();
        bus.mask_we = 1'b0;
        chk("t4_un_num", 32'(bus.int_num), 32'd2);
        serve(3'd2);
        tick();

        // edge on line 6 in the same cycle as its acknowledge
        bus.int_req = 8'h40; tick();
        bus.int_req = 8'h00; tick();
        chk("t5_num", 32'(bus.int_num), 32'd6);
        bus.int_ack = 1'b1; bus.int_req = 8'h40; tick();
        chk("t5_pend_kept", 32'(bus.pending), 32'h40);
        chk("t5_in_svc",    32'(bus.in_service), 32'd1);
        bus.int_ack = 1'b0; bus.int_req = 8'h00; bus.int_done = 1'b1; tick();
        bus.int_done = 1'b0;
        chk("t5_gap", 32'(bus.intr), 32'd0);
        tick();
        chk("t5_again", 32'(bus.int_num), 32'd6);
        chk("t5_intr",  32'(bus.intr), 32'd1);
        serve(3'd6);
        tick();

        // asynchronous reset during service
        bus.int_req = 8'h10; tick();
        bus.int_req = 8'h00; tick();
        bus.int_ack = 1'b1; tick();
        bus.int_ack = 1'b0;
        chk("t6_in_svc", 32'(bus.in_service), 32'd1);
        bus.int_req = 8'h02;
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_in_svc", 32'(bus.in_service), 32'd0);
        chk("t6_rst_pend",   32'(bus.pending), 32'h00);
        chk("t6_rst_intr",   32'(bus.intr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("t6_e0_pend", 32'(bus.pending), 32'h02);
        chk("t6_e0_intr", 32'(bus.intr), 32'd0);
        tick();
        chk("t6_intr", 32'(bus.intr), 32'd1);
        chk("t6_num",  32'(bus.int_num), 32'd1);
        serve(3'd1);
        bus.int_req = 8'h00;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
